// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one single-ported memory between instruction fetch (0) and data access (1).
// The winning request is latched on the grant edge; each transaction ends with a done pulse or a timeout abort.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              we1_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              sel_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic [7:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       ack_done;
    logic       tmo_done;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        ack_done  = 1'b0;
        tmo_done  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins
                if (req0_i && (!req1_i || last)) begin
                    grant0    = 1'b1;
                    state_nxt = GRANT0;
                end else if (req1_i) begin
                    grant1    = 1'b1;
                    state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // An ack in the timeout cycle still counts as a normal completion
                if (mem_ack_i) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == TMO_LAST) begin
                    tmo_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            sel_o       <= 1'b0;
            rdata_o     <= '0;
            done0_o     <= 1'b0;
            done1_o     <= 1'b0;
            err_o       <= 1'b0;
            cnt         <= '0;
            last        <= 1'b1;
        end else begin
            done0_o <= 1'b0;
            done1_o <= 1'b0;
            err_o   <= 1'b0;
            if (grant0 || grant1) begin
                mem_req_o   <= 1'b1;
                sel_o       <= grant1;
                mem_addr_o  <= grant1 ? addr1_i  : addr0_i;
                mem_wdata_o <= grant1 ? wdata1_i : wdata0_i;
                mem_we_o    <= grant1 ? we1_i    : we0_i;
                cnt         <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 8'd1;
                if (ack_done || tmo_done) begin
                    mem_req_o <= 1'b0;
                    last      <= (state == GRANT1);
                    done0_o   <= (state == GRANT0);
                    done1_o   <= (state == GRANT1);
                    err_o     <= tmo_done;
                    rdata_o   <= ack_done ? mem_rdata_i : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: scenario tasks drive the requesters and memory, a scoreboard checks every completion.
module tb_mem_port_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int ACK_TIMEOUT = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req0_i = 1'b0;
    logic [ADDR_W-1:0] addr0_i = '0;
    logic [DATA_W-1:0] wdata0_i = '0;
    logic              we0_i = 1'b0;
    logic              req1_i = 1'b0;
    logic [ADDR_W-1:0] addr1_i = '0;
    logic [DATA_W-1:0] wdata1_i = '0;
    logic              we1_i = 1'b0;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_we_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              sel_o;
    logic [DATA_W-1:0] rdata_o;
    logic              done0_o;
    logic              done1_o;
    logic              err_o;

    typedef struct {
        logic              idx;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req0_i     (req0_i),
        .addr0_i    (addr0_i),
        .wdata0_i   (wdata0_i),
        .we0_i      (we0_i),
        .req1_i     (req1_i),
        .addr1_i    (addr1_i),
        .wdata1_i   (wdata1_i),
        .we1_i      (we1_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_we_o   (mem_we_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .sel_o      (sel_o),
        .rdata_o    (rdata_o),
        .done0_o    (done0_o),
        .done1_o    (done1_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Every done/err pulse must match the oldest expected completion
    always @(negedge clk_i) begin
        if (done0_o === 1'b1 || done1_o === 1'b1 || err_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done0=%b done1=%b err=%b, required no pulse",
                         done0_o, done1_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({done1_o, done0_o, err_o, rdata_o} !== {mon_e.idx, ~mon_e.idx, mon_e.err, mon_e.rdata}) begin
                    errors++;
                    $display("FAIL completion: got done1=%b done0=%b err=%b rdata=%h, required done1=%b done0=%b err=%b rdata=%h",
                             done1_o, done0_o, err_o, rdata_o, mon_e.idx, ~mon_e.idx, mon_e.err, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish within 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, sel_o, rdata_o, done0_o, done1_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h wdata=%h we=%b sel=%b rdata=%h, required all 0",
                     mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, sel_o, rdata_o);
        end
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ack_i   = (i == 2);
            mem_rdata_i = 32'hBAD0_0000;
            tick();
            checks++;
            if ({mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, sel_o, rdata_o, done0_o, done1_o, err_o} !== '0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d got req=%b rdata=%h done0=%b done1=%b err=%b, required all 0",
                         i, mem_req_o, rdata_o, done0_o, done1_o, err_o);
            end
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_single_read();
        req0_i  = 1'b1;
        addr0_i = 32'h40;
        we0_i   = 1'b0;
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o, sel_o, mem_we_o} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_grant: got req=%b addr=%h sel=%b we=%b, required req=1 addr=00000040 sel=0 we=0",
                     mem_req_o, mem_addr_o, sel_o, mem_we_o);
        end
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        exp_q.push_back('{idx: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
        tick();
        mem_ack_i = 1'b0;
        req0_i    = 1'b0;
        checks++;
        if ({done0_o, rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_done: got done0=%b rdata=%h, required done0=1 rdata=deadbeef", done0_o, rdata_o);
        end
        tick();
        checks++;
        if ({done0_o, mem_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL read_single_pulse: got done0=%b req=%b, required 0 0", done0_o, mem_req_o);
        end
    endtask

    task automatic test_round_robin();
        logic exp_idx;
        apply_reset();
        req0_i  = 1'b1;
        addr0_i = 32'h10;
        req1_i  = 1'b1;
        addr1_i = 32'h20;
        for (int i = 0; i < 4; i++) begin
            exp_idx = i[0];
            tick();
            checks++;
            if ({mem_req_o, sel_o, mem_addr_o} !== {1'b1, exp_idx, (exp_idx ? 32'h20 : 32'h10)}) begin
                errors++;
                $display("FAIL rr_grant: txn %0d got req=%b sel=%b addr=%h, required req=1 sel=%b",
                         i, mem_req_o, sel_o, mem_addr_o, exp_idx);
            end
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hC0DE_0000 + i;
            exp_q.push_back('{idx: exp_idx, rdata: 32'hC0DE_0000 + i, err: 1'b0});
            tick();
            mem_ack_i = 1'b0;
            if (i == 3) begin
                req0_i = 1'b0;
                req1_i = 1'b0;
            end
            checks++;
            if ({mem_req_o, sel_o} !== {1'b0, exp_idx}) begin
                errors++;
                $display("FAIL rr_idle_gap: txn %0d got req=%b sel=%b, required req=0 sel=%b",
                         i, mem_req_o, sel_o, exp_idx);
            end
        end
        tick();
    endtask

    task automatic test_write_stable();
        req1_i   = 1'b1;
        addr1_i  = 32'h100;
        wdata1_i = 32'h12345678;
        we1_i    = 1'b1;
        tick();
        addr1_i  = 32'h200;
        wdata1_i = 32'hFFFFFFFF;
        we1_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req_o, sel_o, mem_addr_o, mem_wdata_o, mem_we_o} !== {1'b1, 1'b1, 32'h100, 32'h12345678, 1'b1}) begin
                errors++;
                $display("FAIL write_stable: cycle %0d got req=%b sel=%b addr=%h wdata=%h we=%b, required 1 1 00000100 12345678 1",
                         i, mem_req_o, sel_o, mem_addr_o, mem_wdata_o, mem_we_o);
            end
            if (i < 2) tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA5A5A5A5;
        exp_q.push_back('{idx: 1'b1, rdata: 32'hA5A5A5A5, err: 1'b0});
        tick();
        mem_ack_i = 1'b0;
        req1_i    = 1'b0;
        checks++;
        if ({done1_o, done0_o} !== 2'b10) begin
            errors++;
            $display("FAIL write_done: got done1=%b done0=%b, required 1 0", done1_o, done0_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        req0_i      = 1'b1;
        addr0_i     = 32'h80;
        mem_rdata_i = 32'h7777_7777;
        tick();
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
            tick();
            checks++;
            if ({mem_req_o, err_o, done0_o} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait: cycle %0d got req=%b err=%b done0=%b, required 1 0 0",
                         i, mem_req_o, err_o, done0_o);
            end
        end
        exp_q.push_back('{idx: 1'b0, rdata: '0, err: 1'b1});
        tick();
        req0_i = 1'b0;
        checks++;
        if ({err_o, done0_o, mem_req_o, rdata_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL timeout_abort: got err=%b done0=%b req=%b rdata=%h, required 1 1 0 00000000",
                     err_o, done0_o, mem_req_o, rdata_o);
        end
        tick();
        req0_i = 1'b1;
        req1_i = 1'b1;
        tick();
        checks++;
        if ({mem_req_o, sel_o} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_next_tie: got req=%b sel=%b, required req=1 sel=1", mem_req_o, sel_o);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        exp_q.push_back('{idx: 1'b1, rdata: 32'h1111_2222, err: 1'b0});
        tick();
        mem_ack_i = 1'b0;
        req0_i    = 1'b0;
        req1_i    = 1'b0;
        tick();
        req0_i = 1'b1;
        tick();
        for (int i = 1; i < ACK_TIMEOUT; i++) tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h600DF00D;
        exp_q.push_back('{idx: 1'b0, rdata: 32'h600DF00D, err: 1'b0});
        tick();
        mem_ack_i = 1'b0;
        req0_i    = 1'b0;
        checks++;
        if ({err_o, done0_o, rdata_o} !== {1'b0, 1'b1, 32'h600DF00D}) begin
            errors++;
            $display("FAIL ack_at_timeout: got err=%b done0=%b rdata=%h, required 0 1 600df00d",
                     err_o, done0_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req1_i  = 1'b1;
        addr1_i = 32'h300;
        we1_i   = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, sel_o, rdata_o, done0_o, done1_o, err_o} !== '0) begin
            errors++;
            $display("FAIL midgrant_reset: got req=%b addr=%h sel=%b rdata=%h done1=%b, required all 0",
                     mem_req_o, mem_addr_o, sel_o, rdata_o, done1_o);
        end
        rst_i       = 1'b1;
        req1_i      = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if ({done1_o, mem_req_o, rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL late_ack_ignored: got done1=%b req=%b rdata=%h, required 0 0 00000000",
                     done1_o, mem_req_o, rdata_o);
        end
        req0_i  = 1'b1;
        addr0_i = 32'h44;
        req1_i  = 1'b1;
        tick();
        checks++;
        if ({mem_req_o, sel_o, mem_addr_o} !== {1'b1, 1'b0, 32'h44}) begin
            errors++;
            $display("FAIL reset_next_tie: got req=%b sel=%b addr=%h, required 1 0 00000044",
                     mem_req_o, sel_o, mem_addr_o);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BAD_CAFE;
        exp_q.push_back('{idx: 1'b0, rdata: 32'h0BAD_CAFE, err: 1'b0});
        tick();
        mem_ack_i = 1'b0;
        req0_i    = 1'b0;
        req1_i    = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stable();
        test_timeout();
        test_reset_mid_grant();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d completions outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: requester 0 is instruction fetch, requester 1 is data access.
- Round-robin arbitration with a registered FSM.
- Latches the winning request and drives the memory-side 2:1 data/address select through sel_o.
- Returns read data with a one-cycle done pulse per requester, and bounds memory latency with an ack timeout.

Parameters:
- ADDR_W, 32, address width of requesters and memory port
- DATA_W, 32, data width
- ACK_TIMEOUT, 16, maximum cycles in a grant state without mem_ack_i before abort; legal range 2..255

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low
- req0_i  in  1  requester 0 request; held with stable addr/data until done0_o
- addr0_i  in  ADDR_W  requester 0 address
- wdata0_i  in  DATA_W  requester 0 write data
- we0_i  in  1  requester 0 write enable
- req1_i  in  1  requester 1 request
- addr1_i  in  ADDR_W  requester 1 address
- wdata1_i  in  DATA_W  requester 1 write data
- we1_i  in  1  requester 1 write enable
- mem_req_o  out  1  memory request, high for whole transaction
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched write data
- mem_we_o  out  1  latched write enable
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- sel_o  out  1  datapath mux select: 0 = requester 0, 1 = requester 1
- rdata_o  out  DATA_W  registered read data to requesters
- done0_o  out  1  one-cycle completion pulse, requester 0
- done1_o  out  1  one-cycle completion pulse, requester 1
- err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, sel_o, rdata_o, done0_o, done1_o, err_o.
  - Timeout counter goes to 0.
  - Round-robin pointer last goes to 1, so requester 0 wins the first tie.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only req0_i=1: go to GRANT0.
  - Only req1_i=1: go to GRANT1.
  - Both requesting: grant the requester not equal to last.
  - Neither requesting: stay in IDLE.
  - On the grant edge:
    - Latch that requester's addr/wdata/we into the mem_* registers.
    - Set sel_o to the granted index and mem_req_o=1.
    - Clear the counter.
- GRANTx:
  - mem_req_o stays 1 and the mem_* outputs stay stable.
  - Counter increments every cycle.
  - mem_ack_i=1:
    - rdata_o <= mem_rdata_i (for writes too; requesters ignore it).
    - donex_o pulses 1 for the next cycle.
    - last <= x; mem_req_o <= 0; state goes to IDLE.
  - No ack, counter reaches ACK_TIMEOUT-1:
    - err_o and donex_o pulse together; rdata_o <= 0.
    - last <= x; mem_req_o <= 0; state goes to IDLE.
  - A mem_ack_i arriving in the same cycle the timeout fires takes precedence: normal completion, no err_o.
- Latency:
  - Request seen in IDLE at edge n: mem_req_o high from n+1.
  - mem_ack_i sampled at edge m: donex_o and rdata_o valid during cycle m+1.
  - Minimum request-to-done time is 3 cycles.
  - There is one mandatory IDLE cycle between transactions.
- sel_o changes only on a grant edge and holds its value through IDLE. It is never driven from the req inputs combinationally.
- Requests dropped mid-grant are ignored; the transaction completes and done still pulses.
- Requester inputs changing mid-grant do not affect the mem_* outputs.
- mem_ack_i in IDLE is ignored: no done, no rdata_o update.
- done0_o and done1_o are never high in the same cycle.
- Synchronous reset asserted mid-grant aborts the transaction with no done/err pulse; any later ack is ignored.

Test Plan:
- Reset hold, then release with no requests: all outputs 0 and state IDLE for 5 cycles; mem_ack_i pulsed in IDLE produces no done.
- req0_i=1, addr0_i=0x40, we0_i=0; memory acks 2 cycles after mem_req_o rises with rdata 0xDEADBEEF:
  - mem_addr_o=0x40 and sel_o=0.
  - done0_o pulses exactly once, with rdata_o=0xDEADBEEF in that cycle.
- req0_i and req1_i held high together for 4 transactions, immediate ack:
  - Grant order 0,1,0,1.
  - sel_o matches each grant; one IDLE cycle between transactions.
- req1_i write, addr1_i=0x100, wdata1_i=0x12345678, we1_i=1; addr1_i changed to 0x200 mid-grant:
  - mem_addr_o stays 0x100, mem_wdata_o stays 0x12345678, mem_we_o=1.
  - done1_o pulses on ack.
- req0_i with no ack and ACK_TIMEOUT=16:
  - err_o and done0_o pulse together 16 cycles after mem_req_o rises, with rdata_o=0.
  - Next tie goes to requester 1.
  - Repeat with ack in the timeout cycle: no err_o.
- rst_i driven low 2 cycles into a GRANT1 transaction, then ack arriving after release:
  - State IDLE, all outputs 0, no done1_o.
  - Next tie grants requester 0.
